alu_result_queue: RTL and testbench

- Downstream stage of the 4-bit add/sub unit. It captures each result word (s, v, m) that the adder produces when a transfer is qualified by a valid/ready handshake.
- It derives the zero and negative flags and buffers entries in a small circular FIFO for the writeback logic.
- It keeps a sticky overflow flag and a saturating overflow-event counter for debug and exception logic.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_result_queue_if.sv | 31 +++
 rtl/ovf_tracker.sv | 35 +++
 rtl/alu_result_queue.sv | 84 ++++++++
 tb/tb_alu_result_queue.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit add/sub datapath and its result queue.
// Holds the operand width, the operation codes and the bit layout of a queued result entry.
package alu_pkg;

    localparam int ALU_W = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Entry layout is {s, v, z, n, m}; s sits above the four flag bits.
    localparam int E_M = 0;
    localparam int E_N = 1;
    localparam int E_Z = 2;
    localparam int E_V = 3;
    localparam int E_S = 4;

    typedef struct packed {
        logic [ALU_W-1:0] s;
        logic             v;
        logic             z;
        logic             n;
        logic             m;
    } alu_entry_t;

endpackage

// File: rtl/alu_result_queue_if.sv
// Producer and consumer handshake bundle for the ALU result queue.
// Both sides transfer on a cycle where valid && ready; valid must not depend on ready.
interface alu_result_queue_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_s;
    logic             in_v;
    logic             in_m;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_s;
    logic             out_v;
    logic             out_z;
    logic             out_n;
    logic             out_m;

    modport master (
        output in_valid, in_s, in_v, in_m, out_ready,
        input  in_ready, out_valid, out_s, out_v, out_z, out_n, out_m
    );

    modport slave (
        input  in_valid, in_s, in_v, in_m, out_ready,
        output in_ready, out_valid, out_s, out_v, out_z, out_n, out_m
    );
endinterface

// File: rtl/ovf_tracker.sv
// Sticky overflow flag plus saturating overflow-event counter.
// A clear in the same cycle as an overflow event is applied first, so the event still counts.
module ovf_tracker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_ovf,
    input  logic             i_clr,
    output logic             o_sticky,
    output logic [CNT_W-1:0] o_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_sticky;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else if (i_clr) begin
            r_sticky <= i_ovf;
            r_cnt    <= i_ovf ? CNT_W'(1) : '0;
        end else if (i_ovf) begin
            r_sticky <= 1'b1;
            if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_sticky = r_sticky;
    assign o_cnt    = r_cnt;
endmodule

// File: rtl/alu_result_queue.sv
// Circular FIFO of adder results with zero/negative flags computed at push time.
// Full/empty comes from the registered occupancy, so in_ready never depends on out_ready.
module alu_result_queue
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    alu_result_queue_if.slave        q,
    input  logic                     clr_ovf,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf_sticky,
    output logic [CNT_W-1:0]         ovf_cnt
);
    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                ENTRY_W = WIDTH + E_S;
    localparam logic [PTR_W:0]    FULL    = (PTR_W + 1)'(DEPTH);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;

    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_entry;
    logic [ENTRY_W-1:0] w_head;

    assign q.in_ready  = (r_count != FULL);
    assign q.out_valid = (r_count != '0);
    assign w_push      = q.in_valid && q.in_ready;
    assign w_pop       = q.out_valid && q.out_ready;

    assign w_entry = {q.in_s, q.in_v, (q.in_s == '0), q.in_s[WIDTH-1], q.in_m};

    // Storage has no reset; only entries below the occupancy are ever observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head  = r_mem[r_rd_ptr];
    assign q.out_s = w_head[E_S +: WIDTH];
    assign q.out_v = w_head[E_V];
    assign q.out_z = w_head[E_Z];
    assign q.out_n = w_head[E_N];
    assign q.out_m = w_head[E_M];
    assign count   = r_count;

    ovf_tracker #(
        .CNT_W (CNT_W)
    ) u_ovf_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_ovf    (w_push && q.in_v),
        .i_clr    (clr_ovf),
        .o_sticky (ovf_sticky),
        .o_cnt    (ovf_cnt)
    );
endmodule

// File: tb/tb_alu_result_queue.sv
// Directed bench for alu_result_queue: a CNT_W=8 instance for queue behaviour and a
// CNT_W=2 instance for counter saturation and clear priority.
module tb_alu_result_queue;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    logic clr_ovf;
    logic clr_ovf2;
    logic [2:0] count;
    logic [2:0] count2;
    logic       ovf_sticky;
    logic       ovf_sticky2;
    logic [7:0] ovf_cnt;
    logic [1:0] ovf_cnt2;

    int total;
    int bad;

    logic [3:0] exp_q[$];

    alu_result_queue_if #(.WIDTH(4)) q ();
    alu_result_queue_if #(.WIDTH(4)) q2 ();

    alu_result_queue #(.WIDTH(4), .DEPTH(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .q          (q.slave),
        .clr_ovf    (clr_ovf),
        .count      (count),
        .ovf_sticky (ovf_sticky),
        .ovf_cnt    (ovf_cnt)
    );

    alu_result_queue #(.WIDTH(4), .DEPTH(4), .CNT_W(2)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .q          (q2.slave),
        .clr_ovf    (clr_ovf2),
        .count      (count2),
        .ovf_sticky (ovf_sticky2),
        .ovf_cnt    (ovf_cnt2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [3:0] s, input logic v, input logic m);
        q.in_valid = 1'b1;
        q.in_s     = s;
        q.in_v     = v;
        q.in_m     = m;
        tick();
        q.in_valid = 1'b0;
    endtask

    task automatic pop_one();
        q.out_ready = 1'b1;
        tick();
        q.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        q.in_valid = 1'b0; q.in_s = '0; q.in_v = 1'b0; q.in_m = 1'b0; q.out_ready = 1'b0;
        q2.in_valid = 1'b0; q2.in_s = '0; q2.in_v = 1'b0; q2.in_m = 1'b0; q2.out_ready = 1'b0;
        clr_ovf = 1'b0;
        clr_ovf2 = 1'b0;
        tick();
        tick();
        total++; if (q.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid actual=%b required=0", q.out_valid); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count actual=%0d required=0", count); end
        total++; if (q.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready actual=%b required=1", q.in_ready); end
        total++; if (ovf_sticky !== 1'b0 || ovf_cnt !== 8'd0) begin bad++; $display("FAIL reset_ovf actual=%b/%0d required=0/0", ovf_sticky, ovf_cnt); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_first_push();
        push_one(4'b1000, 1'b1, OP_ADD);
        total++; if (q.out_valid !== 1'b1) begin bad++; $display("FAIL first_valid actual=%b required=1", q.out_valid); end
        total++; if (q.out_s !== 4'b1000) begin bad++; $display("FAIL first_s actual=%b required=1000", q.out_s); end
        total++; if ({q.out_v, q.out_n, q.out_z, q.out_m} !== 4'b1100) begin bad++; $display("FAIL first_flags actual=%b required=1100", {q.out_v, q.out_n, q.out_z, q.out_m}); end
        total++; if (ovf_sticky !== 1'b1 || ovf_cnt !== 8'd1) begin bad++; $display("FAIL first_ovf actual=%b/%0d required=1/1", ovf_sticky, ovf_cnt); end
        pop_one();
        total++; if (count !== 3'd0 || q.out_valid !== 1'b0) begin bad++; $display("FAIL first_drain actual=%0d/%b required=0/0", count, q.out_valid); end
    endtask

    task automatic test_order();
        push_one(4'b1101, 1'b0, OP_SUB);
        push_one(4'b0000, 1'b0, OP_SUB);
        total++; if (count !== 3'd2) begin bad++; $display("FAIL order_count actual=%0d required=2", count); end
        total++; if ({q.out_s, q.out_n, q.out_z, q.out_m} !== 7'b1101_101) begin bad++; $display("FAIL order_head0 actual=%b required=1101101", {q.out_s, q.out_n, q.out_z, q.out_m}); end
        pop_one();
        total++; if ({q.out_s, q.out_n, q.out_z, q.out_v} !== 7'b0000_010) begin bad++; $display("FAIL order_head1 actual=%b required=0000010", {q.out_s, q.out_n, q.out_z, q.out_v}); end
        pop_one();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL order_empty actual=%0d required=0", count); end
        // out_ready while empty must not move rd_ptr: the next push must come out first
        pop_one();
        push_one(4'b0011, 1'b0, OP_ADD);
        total++; if (q.out_s !== 4'b0011 || count !== 3'd1) begin bad++; $display("FAIL empty_pop actual=%b/%0d required=0011/1", q.out_s, count); end
        pop_one();
    endtask

    task automatic test_full_wrap();
        for (int i = 1; i <= 4; i++) begin
            push_one(4'(i), 1'b0, OP_ADD);
        end
        total++; if (q.in_ready !== 1'b0 || count !== 3'd4) begin bad++; $display("FAIL full_state actual=%b/%0d required=0/4", q.in_ready, count); end
        q.in_valid = 1'b1; q.in_s = 4'd5; q.in_v = 1'b0; q.in_m = OP_ADD;
        tick();
        tick();
        total++; if (count !== 3'd4 || q.out_s !== 4'd1) begin bad++; $display("FAIL full_hold actual=%0d/%0d required=4/1", count, q.out_s); end
        q.out_ready = 1'b1;
        tick();
        q.out_ready = 1'b0;
        total++; if (count !== 3'd3 || q.in_ready !== 1'b1) begin bad++; $display("FAIL full_pop_refuse actual=%0d/%b required=3/1", count, q.in_ready); end
        tick();
        q.in_valid = 1'b0;
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_accept5 actual=%0d required=4", count); end
        for (int i = 2; i <= 5; i++) begin
            total++; if (q.out_s !== 4'(i)) begin bad++; $display("FAIL wrap_order actual=%0d required=%0d", q.out_s, i); end
            pop_one();
        end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL wrap_empty actual=%0d required=0", count); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] nv;
        exp_q.delete();
        push_one(4'h6, 1'b0, OP_ADD); exp_q.push_back(4'h6);
        push_one(4'h7, 1'b0, OP_ADD); exp_q.push_back(4'h7);
        for (int i = 0; i < 10; i++) begin
            nv = 4'(8 + i);
            q.in_valid = 1'b1; q.in_s = nv; q.in_v = 1'b0; q.in_m = OP_ADD;
            q.out_ready = 1'b1;
            total++; if (q.out_s !== exp_q[0]) begin bad++; $display("FAIL b2b_head actual=%h required=%h", q.out_s, exp_q[0]); end
            tick();
            void'(exp_q.pop_front());
            exp_q.push_back(nv);
            total++; if (count !== 3'd2) begin bad++; $display("FAIL b2b_count actual=%0d required=2", count); end
        end
        q.in_valid = 1'b0;
        q.out_ready = 1'b0;
        while (exp_q.size() > 0) begin
            total++; if (q.out_s !== exp_q[0]) begin bad++; $display("FAIL b2b_drain actual=%h required=%h", q.out_s, exp_q[0]); end
            pop_one();
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_ovf_sat();
        logic [1:0] exp_cnt;
        q2.out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            q2.in_valid = 1'b1; q2.in_s = 4'b1000; q2.in_v = 1'b1; q2.in_m = OP_ADD;
            tick();
            exp_cnt = (i > 3) ? 2'd3 : 2'(i);
            total++; if (ovf_cnt2 !== exp_cnt || ovf_sticky2 !== 1'b1) begin bad++; $display("FAIL sat_cnt actual=%0d/%b required=%0d/1", ovf_cnt2, ovf_sticky2, exp_cnt); end
        end
        clr_ovf2 = 1'b1;
        tick();
        total++; if (ovf_cnt2 !== 2'd1 || ovf_sticky2 !== 1'b1) begin bad++; $display("FAIL clr_with_push actual=%0d/%b required=1/1", ovf_cnt2, ovf_sticky2); end
        q2.in_valid = 1'b0;
        tick();
        clr_ovf2 = 1'b0;
        total++; if (ovf_cnt2 !== 2'd0 || ovf_sticky2 !== 1'b0) begin bad++; $display("FAIL clr_alone actual=%0d/%b required=0/0", ovf_cnt2, ovf_sticky2); end
        tick();
        q2.out_ready = 1'b0;
        total++; if (count2 !== 3'd0) begin bad++; $display("FAIL sat_drain actual=%0d required=0", count2); end
    endtask

    task automatic test_reset_mid();
        push_one(4'h1, 1'b0, OP_ADD);
        push_one(4'h2, 1'b1, OP_ADD);
        push_one(4'h3, 1'b0, OP_ADD);
        total++; if (count !== 3'd3 || ovf_sticky !== 1'b1) begin bad++; $display("FAIL mid_pre actual=%0d/%b required=3/1", count, ovf_sticky); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (q.out_valid !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL mid_rst_q actual=%b/%0d required=0/0", q.out_valid, count); end
        total++; if (ovf_sticky !== 1'b0 || ovf_cnt !== 8'd0) begin bad++; $display("FAIL mid_rst_ovf actual=%b/%0d required=0/0", ovf_sticky, ovf_cnt); end
        #1;
        rst_n = 1'b1;
        tick();
        push_one(4'hA, 1'b0, OP_SUB);
        total++; if (q.out_s !== 4'hA || count !== 3'd1) begin bad++; $display("FAIL mid_after actual=%h/%0d required=a/1", q.out_s, count); end
        pop_one();
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_first_push();
        test_order();
        test_full_wrap();
        test_back_to_back();
        test_ovf_sat();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
